// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The opcode legality helper backs the optional FETCH_ILLEGAL_CHECK_EN check.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] word;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

  typedef enum logic {
    FETCH_RUN,
    FETCH_HALT
  } fetch_state_t;

  // U-type opcodes are recognised but deliberately reported as unsupported.
  function automatic logic opcode_supported(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_I, OPC_LOAD, OPC_S, OPC_B, OPC_JAL, OPC_JALR: return 1'b1;
      OPC_LUI, OPC_AUIPC:                                      return 1'b0;
      default:                                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with flush; when empty, the head output holds the last
// value that was presented so downstream sees a stable word.
module fetch_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [WIDTH-1:0] hold_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Shadow of the current head, used as the output once the FIFO drains or flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q <= '0;
    end else if (!empty) begin
      hold_q <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head_data = empty ? hold_q : mem[rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && full && !pop));

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC generation, credit-limited memory requests, response FIFO and
// redirect flush. Define FETCH_ILLEGAL_CHECK_EN to flag and halt on unsupported opcodes.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned      XLEN     = fetch_pkg::XLEN,
  parameter int unsigned      DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            decode_ready,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic            inst_illegal
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   outstanding_q;
  logic [CW-1:0]   drop_cnt_q;
  logic [CW-1:0]   inst_count;
  logic [CW-1:0]   pcq_count;
  logic [CW:0]     credit_used;
  fetch_state_t    state_q;
  fetch_state_t    state_d;

  logic            req_fire;
  logic            resp_fire;
  logic            resp_keep;
  logic            pop;
  logic            halted;
  logic            inst_empty;
  logic            inst_full;
  logic            pcq_empty;
  logic            pcq_full;
  logic [XLEN-1:0] pcq_head;
  fetch_entry_t    push_entry;
  fetch_entry_t    head_entry;

  assign halted      = (state_q == FETCH_HALT);
  assign credit_used = {1'b0, outstanding_q} + {1'b0, inst_count};

  assign imem_req_valid = !rst && !halted && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_q;

  assign req_fire  = imem_req_valid & imem_req_ready;
  assign resp_fire = imem_resp_valid;
  assign resp_keep = resp_fire && (drop_cnt_q == '0) && !redirect_valid;
  assign pop       = inst_valid & decode_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      outstanding_q <= outstanding_q + CW'(req_fire) - CW'(resp_fire);
      if (redirect_valid) begin
        pc_q       <= {redirect_pc[XLEN-1:2], 2'b00};
        drop_cnt_q <= outstanding_q + CW'(req_fire) - CW'(resp_fire);
      end else begin
        if (req_fire) pc_q <= pc_q + XLEN'(4);
        if (resp_fire && drop_cnt_q != '0) drop_cnt_q <= drop_cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH_RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = FETCH_RUN;
    end
`ifdef FETCH_ILLEGAL_CHECK_EN
    else if (resp_keep && !opcode_supported(imem_resp_data[6:0])) begin
      state_d = FETCH_HALT;
    end
`endif
  end

  // PC queue holds only live (non-dropped) in-flight request addresses, so its
  // head always pairs with the next response that is kept.
  fetch_fifo #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH)
  ) u_pc_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (req_fire),
    .push_data (pc_q),
    .pop       (resp_keep),
    .head_data (pcq_head),
    .count     (pcq_count),
    .empty     (pcq_empty),
    .full      (pcq_full)
  );

  assign push_entry = '{word: imem_resp_data, pc: pcq_head};

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (resp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .count     (inst_count),
    .empty     (inst_empty),
    .full      (inst_full)
  );

  assign inst_valid = !inst_empty;
  assign inst_data  = head_entry.word;
  assign inst_pc    = head_entry.pc;
  assign opcode     = inst_data[6:0];
  assign funct3     = inst_data[14:12];
  assign funct7     = inst_data[31:25];

`ifdef FETCH_ILLEGAL_CHECK_EN
  assign inst_illegal = inst_valid && !opcode_supported(opcode);
`else
  assign inst_illegal = 1'b0;
`endif

  a_resp_has_pc: assert property (@(posedge clk) disable iff (rst)
    resp_keep |-> !pcq_empty);
  a_pcq_tracks_live: assert property (@(posedge clk) disable iff (rst)
    pcq_count == outstanding_q - drop_cnt_q);
  a_pcq_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(req_fire && !redirect_valid && pcq_full && !resp_keep));
  a_inst_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(resp_keep && inst_full && !pop));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit with an in-order memory model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        decode_ready = 1'b1;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        inst_illegal;

  always #5 clk = ~clk;

  instruction_fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (RST_PC)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .decode_ready    (decode_ready),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc),
    .opcode          (opcode),
    .funct3          (funct3),
    .funct7          (funct7),
    .inst_illegal    (inst_illegal)
  );

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
    int unsigned ep;
  } mreq_t;

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
  } exp_t;

  mreq_t       pend[$];
  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned lat = 1;
  int unsigned epoch = 0;
  int unsigned resp_ep = 0;
  int unsigned n_fire = 0;
  int unsigned n_pop = 0;
  int unsigned n_stale = 0;
  int unsigned n_lui = 0;
  int          first_fire = -1;
  int          first_valid = -1;
  logic [31:0] resp_addr = '0;
  logic [31:0] exp_addr = '0;
  logic [31:0] redir_tgt = '0;
  logic [31:0] first_tgt = '0;
  logic        check_redir_next = 1'b0;
  logic        want_first = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else             n_pass++;
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    if (a == 32'h0000_0300) return 32'h0000_12B7;
    return {a[24:0], 7'h33};
  endfunction

  function automatic logic exp_illegal(input logic [31:0] w);
`ifdef FETCH_ILLEGAL_CHECK_EN
    case (w[6:0])
      7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67: return 1'b0;
      default:                                        return 1'b1;
    endcase
`else
    return (w[6:0] == 7'h7F) && (w[6:0] != 7'h7F);
`endif
  endfunction

  task automatic cycle();
    logic  fire;
    exp_t  e;
    mreq_t m;
    @(negedge clk);
    if (!rst) begin
      fire = imem_req_valid && imem_req_ready;
      if (check_redir_next) begin
        check_eq("redir_next_addr", imem_req_addr, redir_tgt);
        check_eq("redir_next_inst_valid", 32'(inst_valid), 32'd0);
        check_redir_next = 1'b0;
      end
      if (fire && first_fire < 0) first_fire = int'(cyc);
      if (inst_valid && first_valid < 0) first_valid = int'(cyc);
      if (!redirect_valid && inst_valid && decode_ready) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          check_eq("pop_unexpected_valid", 32'(inst_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          if (want_first) begin
            check_eq("first_pc_after_redirect", inst_pc, first_tgt);
            want_first = 1'b0;
          end
          check_eq("inst_pc", inst_pc, e.pc);
          check_eq("inst_data", inst_data, e.word);
          check_eq("opcode", 32'(opcode), 32'(e.word[6:0]));
          check_eq("funct3", 32'(funct3), 32'(e.word[14:12]));
          check_eq("funct7", 32'(funct7), 32'(e.word[31:25]));
          check_eq("inst_illegal", 32'(inst_illegal), 32'(exp_illegal(e.word)));
          if (e.pc == 32'h0000_0300) n_lui++;
        end
      end
      if (fire) begin
        check_eq("req_addr", imem_req_addr, exp_addr);
        pend.push_back('{cyc + lat, imem_req_addr, epoch});
        exp_addr += 32'd4;
        n_fire++;
      end
      if (imem_resp_valid && resp_ep == epoch) exp_q.push_back('{word_of(resp_addr), resp_addr});
      if (redirect_valid) begin
        exp_q.delete();
        epoch++;
        redir_tgt        = {redirect_pc[31:2], 2'b00};
        exp_addr         = redir_tgt;
        check_redir_next = 1'b1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    imem_resp_valid = 1'b0;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      m               = pend.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = word_of(m.addr);
      resp_addr       = m.addr;
      resp_ep         = m.ep;
      if (m.ep != epoch) n_stale++;
    end
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    #1;
    check_eq("rst_inst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check_eq("rst_inst_illegal", 32'(inst_illegal), 32'd0);
    pend.delete();
    exp_q.delete();
    epoch++;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_inst_data", inst_data, 32'd0);
    check_eq("rst_inst_pc", inst_pc, 32'd0);
    rst              = 1'b0;
    exp_addr         = RST_PC;
    check_redir_next = 1'b0;
    want_first       = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] tgt);
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    cycle();
    redirect_valid = 1'b0;
    want_first     = 1'b1;
    first_tgt      = {tgt[31:2], 2'b00};
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #2;
    // 1-cycle memory: first-instruction latency and sustained throughput
    lat = 1; decode_ready = 1'b1;
    do_reset();
    first_fire = -1; first_valid = -1;
    repeat (10) cycle();
    check_eq("first_latency", 32'(first_valid - first_fire), 32'd2);
    n_pop = 0; n_fire = 0;
    repeat (20) cycle();
    check_eq("throughput_pops", n_pop, 32'd20);
    check_eq("throughput_reqs", n_fire, 32'd20);

    // decode stalled: credit limit caps accepted requests at DEPTH
    do_reset();
    decode_ready = 1'b0; n_fire = 0;
    repeat (10) cycle();
    check_eq("stall_reqs", n_fire, 32'd4);
    check_eq("stall_req_valid", 32'(imem_req_valid), 32'd0);
    decode_ready = 1'b1;
    repeat (20) cycle();

    // 3-cycle memory, redirect with 3 requests in flight
    do_reset();
    lat = 3;
    repeat (3) cycle();
    n_stale = 0;
    redirect_to(32'h0000_0200);
    repeat (20) cycle();
    check_eq("stale_dropped", n_stale, 32'd3);
    check_eq("redir_first_seen", 32'(want_first), 32'd0);

    // redirect coinciding with req_fire and resp_fire, misaligned target
    lat = 1;
    repeat (10) cycle();
    for (int i = 0; i < 20; i++) begin
      if (imem_req_valid && imem_resp_valid) break;
      cycle();
    end
    check_eq("coincide_req_resp", 32'(imem_req_valid && imem_resp_valid), 32'd1);
    redirect_to(32'h0000_0203);
    repeat (10) cycle();
    check_eq("misaligned_first_seen", 32'(want_first), 32'd0);

    // lui at 0x300
    redirect_to(32'h0000_02F8);
    n_lui = 0;
    repeat (12) cycle();
    check_eq("lui_popped", n_lui, 32'd1);
    n_fire = 0;
    repeat (5) cycle();
`ifdef FETCH_ILLEGAL_CHECK_EN
    check_eq("halted_no_reqs", n_fire, 32'd0);
`else
    check_eq("no_halt_reqs", n_fire, 32'd5);
`endif
    redirect_to(32'h0000_0400);
    repeat (10) cycle();
    check_eq("resume_first_seen", 32'(want_first), 32'd0);

    // asynchronous reset with three buffered entries
    do_reset();
    decode_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 3) break;
      cycle();
    end
    check_eq("filled_before_reset", 32'(inst_valid), 32'd1);
    do_reset();
    decode_ready = 1'b1;
    n_fire = 0;
    repeat (10) cycle();
    check_eq("post_reset_reqs", 32'(n_fire > 0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
